// File: rtl/adder_pkg.sv
// Shared definitions for the high-speed adder comparison set.
// Every adder in the set takes its default operand width from here so that
// results line up when the adders are compared against each other.
package adder_pkg;

  // Default operand and sum width in bits.
  localparam int unsigned DefaultWidth = 8;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder, purely combinational. This is the cell that the
// ripple chain is built from.
//   a, b : operand bits
//   cin  : carry into this bit
//   sum  : sum bit
//   cout : carry out of this bit
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic p;

  // p is the propagate term, reused by both the sum and the carry.
  assign p    = a ^ b;
  assign sum  = p ^ cin;
  assign cout = (a & b) | (cin & p);

endmodule

// File: rtl/ripple_carry_adder.sv
// Unsigned ripple-carry adder with registered outputs. This is the
// area-minimal baseline of the adder set: WIDTH full adders are chained so
// that the carry moves strictly one bit at a time. The sum and carry-out are
// captured on every rising clock edge, giving one cycle of latency and one
// addition per cycle.
//   clk  : rising-edge clock
//   rst  : synchronous reset, active-high; clears sum and cout
//   a, b : unsigned operands, WIDTH bits
//   cin  : carry into bit 0
//   sum  : registered sum, WIDTH bits
//   cout : registered carry out of bit WIDTH-1
module ripple_carry_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // carry[i] is the carry into bit i; carry[WIDTH] is the final carry-out.
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_d;

  assign carry[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (carry[i]),
      .sum  (sum_d[i]),
      .cout (carry[i+1])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum  <= '0;
      cout <= 1'b0;
    end else begin
      sum  <= sum_d;
      cout <= carry[WIDTH];
    end
  end

endmodule

// File: tb/tb_ripple_carry_adder.sv
// Self-checking bench for ripple_carry_adder at WIDTH = 8, 1 and 16.
// Expected results come from plain integer addition of the operands.
module tb_ripple_carry_adder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic [7:0]  a8 = '0, b8 = '0, sum8;
  logic        cin8 = 1'b0, cout8;
  logic        a1 = 1'b0, b1 = 1'b0, cin1 = 1'b0, sum1, cout1;
  logic [15:0] a16 = '0, b16 = '0, sum16;
  logic        cin16 = 1'b0, cout16;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ripple_carry_adder #(.WIDTH(8)) u_dut8 (
    .clk (clk), .rst (rst), .a (a8), .b (b8), .cin (cin8), .sum (sum8), .cout (cout8)
  );

  ripple_carry_adder #(.WIDTH(1)) u_dut1 (
    .clk (clk), .rst (rst), .a (a1), .b (b1), .cin (cin1), .sum (sum1), .cout (cout1)
  );

  ripple_carry_adder #(.WIDTH(16)) u_dut16 (
    .clk (clk), .rst (rst), .a (a16), .b (b16), .cin (cin16), .sum (sum16), .cout (cout16)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [8:0] exp;  // {cout, sum}
  } vec_t;

  vec_t vecs[10];

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [16:0] act, input logic [16:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: {cout, sum} = a + b + cin in WIDTH+1 bits.
  function automatic logic [16:0] ref_add(input logic [15:0] a, input logic [15:0] b,
                                          input logic cin, input int w);
    logic [16:0] full;
    logic [16:0] mask;
    full = 17'(a) + 17'(b) + 17'(cin);
    mask = (17'd1 << (w + 1)) - 17'd1;
    return full & mask;
  endfunction

  initial begin
    logic [16:0] exp8, exp1, exp16;

    vecs[0] = '{8'h00, 8'h00, 1'b0, 9'h000};
    vecs[1] = '{8'h00, 8'h01, 1'b0, 9'h001};
    vecs[2] = '{8'h00, 8'h01, 1'b1, 9'h002};
    vecs[3] = '{8'h01, 8'h00, 1'b1, 9'h002};
    vecs[4] = '{8'h01, 8'h01, 1'b0, 9'h002};
    vecs[5] = '{8'h01, 8'h01, 1'b1, 9'h003};
    vecs[6] = '{8'hFF, 8'h00, 1'b1, 9'h100};
    vecs[7] = '{8'hFF, 8'h01, 1'b0, 9'h100};
    vecs[8] = '{8'hFF, 8'hFF, 1'b1, 9'h1FF};
    vecs[9] = '{8'h80, 8'h80, 1'b0, 9'h100};

    // Reset held two edges with non-zero operands present.
    rst = 1'b1;
    a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b1;
    a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1;
    a16 = 16'hFFFF; b16 = 16'hFFFF; cin16 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      check("reset_w8", {8'h0, cout8, sum8}, 17'h0);
      check("reset_w1", {15'h0, cout1, sum1}, 17'h0);
      check("reset_w16", {cout16, sum16}, 17'h0);
    end

    // First edge out of reset captures the operands present at that edge.
    rst = 1'b0;
    step();
    check("post_reset_w8", {8'h0, cout8, sum8}, 17'h100);
    check("post_reset_w1", {15'h0, cout1, sum1}, 17'h3);
    check("post_reset_w16", {cout16, sum16}, 17'h1FFFF);

    // Directed table at WIDTH = 8.
    for (int i = 0; i < 10; i++) begin
      a8 = vecs[i].a; b8 = vecs[i].b; cin8 = vecs[i].cin;
      step();
      check($sformatf("table_%0d", i), {8'h0, cout8, sum8}, {8'h0, vecs[i].exp});
    end

    // Outputs hold while inputs change between edges.
    a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0;
    #2;
    check("hold_w8", {8'h0, cout8, sum8}, {8'h0, vecs[9].exp});
    step();
    check("after_hold_w8", {8'h0, cout8, sum8}, 17'h046);

    // WIDTH = 1 exhaustive; WIDTH = 16 carry through all bits.
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      a1 = v[2]; b1 = v[1]; cin1 = v[0];
      step();
      check($sformatf("w1_exh_%0d", i), {15'h0, cout1, sum1},
            17'(int'(v[2]) + int'(v[1]) + int'(v[0])));
    end
    a16 = 16'hFFFF; b16 = 16'h0000; cin16 = 1'b1;
    step();
    check("w16_ripple", {cout16, sum16}, 17'h10000);

    // Back-to-back random operands, new vector every cycle.
    for (int i = 0; i < 1000; i++) begin
      a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      a1 = 1'($urandom); b1 = 1'($urandom); cin1 = 1'($urandom);
      a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom);
      exp8 = ref_add({8'h0, a8}, {8'h0, b8}, cin8, 8);
      exp1 = ref_add({15'h0, a1}, {15'h0, b1}, cin1, 1);
      exp16 = ref_add(a16, b16, cin16, 16);
      step();
      check("rand_w8", {8'h0, cout8, sum8}, exp8);
      check("rand_w1", {15'h0, cout1, sum1}, exp1);
      check("rand_w16", {cout16, sum16}, exp16);
    end

    // Reset mid-stream discards operands, then next edge captures fresh ones.
    rst = 1'b1;
    a8 = 8'hC3; b8 = 8'h3C; cin8 = 1'b1;
    step();
    check("midreset_w8", {8'h0, cout8, sum8}, 17'h0);
    rst = 1'b0;
    a8 = 8'h10; b8 = 8'h20; cin8 = 1'b1;
    step();
    check("midreset_release_w8", {8'h0, cout8, sum8}, 17'h031);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ripple_carry_adder.md
# ripple_carry_adder

Parameterised unsigned binary adder built as a chain of single-bit full adders, with carry-in and carry-out. The combinational ripple result is captured in an output register on each clock edge. It serves as the area-minimal baseline adder in the high-speed adder set, against which faster adders are compared for function and timing.

## Interface
- WIDTH, default 8, operand and sum width in bits (≥1)
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high; one clock, reset is synchronous and active-high
- a  input  WIDTH  operand A, unsigned
- b  input  WIDTH  operand B, unsigned
- cin  input  1  carry into bit 0
- sum  output  WIDTH  registered sum bits
- cout  output  1  registered carry out of bit WIDTH-1

## Operation
- Bit i computes s_i = a[i] ^ b[i] ^ c_i and c_{i+1} = (a[i] & b[i]) | (c_i & (a[i] ^ b[i])).
- c_0 = cin; carry-out is c_WIDTH.
- Carry propagates strictly bit-serially through the chain: no lookahead, carry-select or prefix logic.
- Arithmetic: {cout, sum} = a + b + cin, exact in WIDTH+1 bits, so there is no overflow loss.
- Unsigned only: no signed-overflow flag is produced.
- Maximum result: a = b = all-ones and cin = 1 gives sum = all-ones, cout = 1.
- No handshake: new operands are accepted on every clock.
- Every edge with rst low loads the current combinational result into sum/cout.
- X/Z on inputs is not filtered and simply propagates.

## Timing
- Latency is exactly 1 cycle: operands present before rising edge N appear on sum/cout after edge N.
- Throughput is one addition per cycle.
- Reset: if rst is high at a rising edge, then sum = 0 and cout = 0 after that edge, regardless of a, b and cin.
- Reset dominates: operands applied during reset are discarded and are not replayed.
- Reset mid-stream: the first edge with rst low captures the operands present at that edge.
- Outputs hold their value between edges. Input changes between edges have no effect on the outputs.
- Critical path is a → c_WIDTH, which is O(WIDTH) full-adder carry delays. The clock period must cover it; no multicycle path is permitted.

## Structure
- Sub-module full_adder (ports a, b, cin, sum, cout, all 1 bit, purely combinational).
  - ripple_carry_adder instantiates WIDTH copies in a generate loop.
  - Carries run on an internal WIDTH+1 bit carry vector.
- Shared package adder_pkg holds the default operand width constant (8).
  - Every adder in the comparison set uses this constant so that widths match.
- The output register lives in ripple_carry_adder only. full_adder stays clock-free.

## Test plan
- Reset: rst = 1 for 2 cycles with a = 8'hAA, b = 8'h55, cin = 1 -> sum = 0, cout = 0. After rst drops, the next edge gives sum = 8'h00, cout = 1.
- Small operands, checked one cycle after each apply:
  - 0+0+0 -> sum 0, cout 0
  - 0+1+0 -> sum 1
  - 0+1+1 -> sum 2
  - 1+0+1 -> sum 2
  - 1+1+0 -> sum 2
  - 1+1+1 -> sum 3
  - cout = 0 in all six cases
- Full carry ripple: a = 8'hFF, b = 8'h00, cin = 1 -> sum = 8'h00, cout = 1. Then a = 8'hFF, b = 8'h01, cin = 0 -> same result.
- Maximum: a = 8'hFF, b = 8'hFF, cin = 1 -> sum = 8'hFF, cout = 1. Then a = 8'h80, b = 8'h80, cin = 0 -> sum = 8'h00, cout = 1.
- Back-to-back: change operands every cycle for 1000 random vectors. Each output must equal a + b + cin of the previous cycle (9-bit compare), with no bubbles.
- Parameter sweep: WIDTH = 1 and WIDTH = 16. Exhaustive for WIDTH = 1 (8 cases); for WIDTH = 16, 16'hFFFF + 16'h0000 + 1 -> sum = 0, cout = 1.
